dmem_responder: RTL



---
 rtl/dmem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store port: single-port word RAM, one-cycle stores,
// loads returned after LATENCY cycles with stall back-pressure. Define DMEM_ERR_EN to flag out-of-range accesses.
module dmem_responder #(
    parameter int ADDR       = 16,
    parameter int W_OPR      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_v_i,
    input  logic             req_we_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic [W_OPR-1:0] wdata_i,
    output logic [W_OPR-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             stall_o,
    output logic             err_o
);
    localparam int DEPTH = 2**DEPTH_LOG2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0] idx_cap_reg, idx_cap_next;
    logic                  oor_cap_reg, oor_cap_next;
    logic                  rvalid_next;
    logic                  rd_en, rd_zero, wr_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  accept, oor;
    logic [DEPTH_LOG2-1:0] idx;
    logic [W_OPR-1:0]      mem [DEPTH];

    assign idx     = addr_i[DEPTH_LOG2-1:0];
    // Nothing is accepted while reset is held, so the RAM cannot change during reset.
    assign accept  = reset && req_v_i && (state_reg == IDLE);
    assign stall_o = (state_reg == BUSY);

`ifdef DMEM_ERR_EN
    logic err_reg;

    assign oor   = |(addr_i >> DEPTH_LOG2);
    assign err_o = err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept && oor;
        end
    end
`else
    // Upper address bits alias onto the RAM when range checking is off.
    logic [ADDR-1:0] addr_unused;

    assign addr_unused = addr_i;
    assign oor         = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_cap_next = idx_cap_reg;
        oor_cap_next = oor_cap_reg;
        rvalid_next  = 1'b0;
        rd_en        = 1'b0;
        rd_idx       = idx;
        rd_zero      = oor;
        wr_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_we_i) begin
                        wr_en = !oor;
                    end else if (LATENCY == 1) begin
                        rd_en       = 1'b1;
                        rvalid_next = 1'b1;
                    end else begin
                        state_next   = BUSY;
                        cnt_next     = 4'(LATENCY - 1);
                        idx_cap_next = idx;
                        oor_cap_next = oor;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 4'd1;
                // Final busy cycle: fetch so the data and rvalid land together next cycle.
                if (cnt_reg == 4'd1) begin
                    rd_en       = 1'b1;
                    rd_idx      = idx_cap_reg;
                    rd_zero     = oor_cap_reg;
                    rvalid_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_cap_reg <= '0;
            oor_cap_reg <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_cap_reg <= idx_cap_next;
            oor_cap_reg <= oor_cap_next;
            rvalid_o    <= rvalid_next;
            if (rd_en) begin
                rdata_o <= rd_zero ? '0 : mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata_i;
        end
    end

endmodule
